// File: rtl/fpga_burst_bridge.sv
// Purpose: bridges a cache-line burst port onto a narrow shared address/data memory bus.
// Latency: one address cycle, then BEATS*SUB bus words; each read beat strobes one cycle after its last word.
// Backpressure: every bus phase advances only on resp_m_to_c; a watchdog aborts a phase that stalls too long.
module fpga_burst_bridge #(
    parameter int ADDR_W  = 32,
    parameter int BUS_W   = 32,
    parameter int CACHE_W = 64,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_W-1:0]                    bmem_addr,
    input  logic                                 bmem_read,
    input  logic                                 bmem_write,
    input  logic [CACHE_W-1:0]                   bmem_wdata,
    output logic                                 bmem_ready,
    output logic [ADDR_W-1:0]                    bmem_raddr,
    output logic [CACHE_W-1:0]                   bmem_rdata,
    output logic                                 bmem_rvalid,
    output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] bmem_wbeat,
    output logic                                 bmem_err,
    input  logic [BUS_W-1:0]                     address_data_bus_m_to_c,
    input  logic                                 resp_m_to_c,
    output logic [BUS_W-1:0]                     address_data_bus_c_to_m,
    output logic                                 address_on_c_to_m,
    output logic                                 data_on_c_to_m,
    output logic                                 read_en_c_to_m,
    output logic                                 write_en_c_to_m
);

    localparam int SUB   = CACHE_W / BUS_W;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int WB_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_WRESP = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]         state;
    logic [CACHE_W-1:0] shift;      // outgoing write beat, consumed low word first
    logic [CACHE_W-1:0] asm_beat;   // read beat under assembly
    logic [CACHE_W-1:0] asm_nx;
    logic [CACHE_W-1:0] shift_nx;
    logic [SUB_W-1:0]   sub_cnt;
    logic [WB_W-1:0]    rbeat;
    logic [WD_W-1:0]    wd;
    logic               reload;     // one bubble cycle so the cache can present the next write beat
    logic               active;
    logic               wd_hit;

    assign shift_nx = shift >> BUS_W;
    assign active   = (state == S_ADDR) || (state == S_WDATA) ||
                      (state == S_WRESP) || (state == S_RDATA);
    // Expiry only when this cycle brings no response: a response on the last cycle wins.
    assign wd_hit   = (TIMEOUT != 0) && active && !resp_m_to_c &&
                      (wd == WD_W'(TIMEOUT - 1));

    // Insert the incoming bus word into its sub-word slot of the beat under assembly.
    always_comb begin
        asm_nx = asm_beat;
        asm_nx[int'(sub_cnt) * BUS_W +: BUS_W] = address_data_bus_m_to_c;
    end

    // Main controller: phase sequencing, bus drive, beat assembly and watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                   <= S_IDLE;
            shift                   <= '0;
            asm_beat                <= '0;
            sub_cnt                 <= '0;
            rbeat                   <= '0;
            wd                      <= '0;
            reload                  <= 1'b0;
            bmem_ready              <= 1'b0;
            bmem_raddr              <= '0;
            bmem_rdata              <= '0;
            bmem_rvalid             <= 1'b0;
            bmem_wbeat              <= '0;
            bmem_err                <= 1'b0;
            address_data_bus_c_to_m <= '0;
            address_on_c_to_m       <= 1'b0;
            data_on_c_to_m          <= 1'b0;
            read_en_c_to_m          <= 1'b0;
            write_en_c_to_m         <= 1'b0;
        end else begin
            bmem_rvalid <= 1'b0;
            bmem_err    <= 1'b0;
            if (active) begin
                wd <= resp_m_to_c ? '0 : wd + WD_W'(1);
            end

            if (wd_hit) begin
                state                   <= S_ERR;
                address_data_bus_c_to_m <= '0;
                address_on_c_to_m       <= 1'b0;
                data_on_c_to_m          <= 1'b0;
                read_en_c_to_m          <= 1'b0;
                write_en_c_to_m         <= 1'b0;
                reload                  <= 1'b0;
                bmem_err                <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bmem_write || bmem_read) begin
                            state                   <= S_ADDR;
                            bmem_ready              <= 1'b0;
                            address_data_bus_c_to_m <= BUS_W'(bmem_addr);
                            address_on_c_to_m       <= 1'b1;
                            data_on_c_to_m          <= 1'b0;
                            write_en_c_to_m         <= bmem_write;
                            read_en_c_to_m          <= !bmem_write;
                            wd                      <= '0;
                            sub_cnt                 <= '0;
                            rbeat                   <= '0;
                            bmem_wbeat              <= '0;
                            reload                  <= 1'b0;
                            if (bmem_write) begin
                                shift <= bmem_wdata;
                            end else begin
                                bmem_raddr <= bmem_addr;
                            end
                        end else begin
                            bmem_ready <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        if (resp_m_to_c) begin
                            address_on_c_to_m <= 1'b0;
                            data_on_c_to_m    <= 1'b1;
                            if (write_en_c_to_m) begin
                                state                   <= S_WDATA;
                                address_data_bus_c_to_m <= shift[BUS_W-1:0];
                            end else begin
                                state                   <= S_RDATA;
                                address_data_bus_c_to_m <= '0;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (reload) begin
                            reload                  <= 1'b0;
                            shift                   <= bmem_wdata;
                            address_data_bus_c_to_m <= bmem_wdata[BUS_W-1:0];
                            data_on_c_to_m          <= 1'b1;
                        end else if (resp_m_to_c) begin
                            if (sub_cnt == SUB_W'(SUB - 1)) begin
                                sub_cnt                 <= '0;
                                data_on_c_to_m          <= 1'b0;
                                address_data_bus_c_to_m <= '0;
                                if (bmem_wbeat == WB_W'(BEATS - 1)) begin
                                    state <= S_WRESP;
                                end else begin
                                    bmem_wbeat <= bmem_wbeat + WB_W'(1);
                                    reload     <= 1'b1;
                                end
                            end else begin
                                sub_cnt                 <= sub_cnt + SUB_W'(1);
                                shift                   <= shift_nx;
                                address_data_bus_c_to_m <= shift_nx[BUS_W-1:0];
                            end
                        end
                    end
                    S_WRESP: begin
                        if (resp_m_to_c) begin
                            state           <= S_DONE;
                            write_en_c_to_m <= 1'b0;
                            bmem_wbeat      <= '0;
                            bmem_ready      <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (!bmem_write) begin
                            state <= S_IDLE;
                        end
                    end
                    S_RDATA: begin
                        if (resp_m_to_c) begin
                            asm_beat <= asm_nx;
                            if (sub_cnt == SUB_W'(SUB - 1)) begin
                                sub_cnt     <= '0;
                                bmem_rdata  <= asm_nx;
                                bmem_rvalid <= 1'b1;
                                if (rbeat == WB_W'(BEATS - 1)) begin
                                    state          <= S_IDLE;
                                    read_en_c_to_m <= 1'b0;
                                    data_on_c_to_m <= 1'b0;
                                    bmem_ready     <= 1'b1;
                                end else begin
                                    rbeat <= rbeat + WB_W'(1);
                                end
                            end else begin
                                sub_cnt <= sub_cnt + SUB_W'(1);
                            end
                        end
                    end
                    S_ERR: begin
                        if (!bmem_read && !bmem_write) begin
                            state      <= S_IDLE;
                            bmem_ready <= 1'b1;
                            bmem_wbeat <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fpga_burst_bridge.md
# fpga_burst_bridge

Parametrised successor to the cache-to-FPGA-memory burst controller. It sits between the cache-side `bmem_*` burst port and the narrow shared address/data bus to the FPGA memory. It serialises one cache line per transaction into `BEATS × (CACHE_W/BUS_W)` bus words and assembles read words back into `CACHE_W` cache beats. Over the earlier controller it adds:
- a generic width and burst length,
- write-over-read arbitration,
- a per-cache-beat read strobe, and
- a response watchdog with an error pulse.

## Interface
Parameters:
- `ADDR_W`, 32, address width (cache side and bus address phase; `ADDR_W ≤ BUS_W`, zero-extended).
- `BUS_W`, 32, memory bus word width.
- `CACHE_W`, 64, cache beat width; must be an integer multiple of `BUS_W`; `SUB = CACHE_W/BUS_W`.
- `BEATS`, 4, cache beats per line (≥1).
- `TIMEOUT`, 1024, maximum cycles waiting for `resp_m_to_c` in any phase; 0 disables the watchdog.

Ports:
- `clk` in 1: the single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `bmem_addr` in `ADDR_W`: line address, sampled on acceptance.
- `bmem_read` in 1: line read request, level.
- `bmem_write` in 1: line write request, level; held until `bmem_ready` is seen in DONE.
- `bmem_wdata` in `CACHE_W`: write beat selected by `bmem_wbeat`.
- `bmem_ready` out 1: controller idle, or write complete.
- `bmem_raddr` out `ADDR_W`: latched address of the current read.
- `bmem_rdata` out `CACHE_W`: assembled read beat.
- `bmem_rvalid` out 1: one-cycle strobe per assembled read beat.
- `bmem_wbeat` out `max(1,$clog2(BEATS))`: index of the write beat the cache must present.
- `bmem_err` out 1: one-cycle pulse on watchdog abort.
- `address_data_bus_m_to_c` in `BUS_W`: read data from memory.
- `resp_m_to_c` in 1: memory accept/response strobe.
- `address_data_bus_c_to_m` out `BUS_W`: address or write data to memory.
- `address_on_c_to_m`, `data_on_c_to_m`, `read_en_c_to_m`, `write_en_c_to_m` out 1: bus phase qualifiers.

## Operation
- All outputs are registered.
- On reset (`rst_n`=0 at an edge), every output goes to 0, including `address_data_bus_c_to_m`, `bmem_rdata`, `bmem_raddr` and `bmem_ready`; state goes to IDLE.
- No output is ever driven X.
- **States:** IDLE, ADDR, WDATA, WRESP, RDATA, DONE, ERR.
- **IDLE**
  - `bmem_ready`=1.
  - `bmem_write` has priority over `bmem_read` when both are high.
  - On accepting a request, latch `bmem_addr` and go to ADDR. For a read, also copy the address to `bmem_raddr`.
  - For a write, capture `bmem_wdata` (beat 0) into the shift register.
- **ADDR**
  - Drive address with `address_on`=1, `data_on`=0, and `read_en`/`write_en` per operation.
  - On `resp_m_to_c`, go to WDATA or RDATA.
- **WDATA**
  - Drive shift-register words low-word-first, with `data_on`=1 and `write_en`=1.
  - Each `resp_m_to_c` accepts one word.
  - After the SUB-th word of beat k: if k<`BEATS`-1, increment `bmem_wbeat` and reload from `bmem_wdata`; otherwise go to WRESP.
  - `bmem_wbeat` advances one cycle before the reload, so the cache has one cycle to present the new beat.
- **WRESP**
  - `write_en`=1, `data_on`=0, `address_on`=0.
  - `resp_m_to_c` marks completion and moves to DONE.
- **DONE**
  - All enables are 0 and `bmem_ready`=1.
  - When `bmem_write`=0, go to IDLE.
- **RDATA**
  - `read_en`=1, `data_on`=1.
  - Each `resp_m_to_c` writes `address_data_bus_m_to_c` into sub-word j of the assembly register.
  - After SUB words, update `bmem_rdata` and pulse `bmem_rvalid` on the next edge.
  - After `BEATS` strobes, go to IDLE.
- **Watchdog**
  - The counter clears on entering ADDR and on every `resp_m_to_c`, and counts in ADDR/WDATA/RDATA/WRESP.
  - When it reaches `TIMEOUT`: drop all enables, pulse `bmem_err`, and go to ERR.
  - A `resp_m_to_c` in the same cycle as expiry wins; there is no error in that case.
  - ERR returns to IDLE once `bmem_read` and `bmem_write` are both 0.
- Changes to `bmem_addr`, `bmem_read` or `bmem_write` after acceptance are ignored until IDLE, except for the DONE and ERR exit conditions.
- After any phase, `address_data_bus_c_to_m` returns to 0 when not driving.

## Timing
- Request seen in IDLE at edge t → address and enables on the bus from t+1.
- `bmem_ready` falls at t+1.
- `resp_m_to_c` is sampled at an edge; the next word appears at the following edge. Zero-wait memory gives one bus word per cycle.
- Read: the last sub-word of a beat is sampled at edge e → `bmem_rvalid`=1 and `bmem_rdata` valid in cycle e+1, for exactly one cycle.
- Back-to-back full-rate read latency: 1 (address) + `BEATS`·SUB + 1 cycles to the last `bmem_rvalid`.
- Write: the completion `resp_m_to_c` at edge e → `bmem_ready`=1 from e+1 until the cycle after `bmem_write` falls.
- `rst_n` low mid-burst: all enables are 0 after that edge, there is no `bmem_rvalid` or `bmem_err`, and the partial line is discarded.

## Test plan
- **Read, defaults, zero-wait:** `bmem_read`, addr 0x0000_1000; resp every cycle with words 1..8 → four `bmem_rvalid` pulses with rdata 0x2_00000001, 0x4_00000003, 0x6_00000005, 0x8_00000007; `bmem_raddr`=0x1000.
- **Write with stalls:** beats 0xA..A, 0xB..B, 0xC..C, 0xD..D; resp delayed 3 cycles per word → bus carries the eight 32-bit halves low-first; `bmem_wbeat` steps 0→3; `bmem_ready` only after WRESP resp, held until `bmem_write` drops.
- **Simultaneous read and write in IDLE:** write transaction first (`write_en`=1 at t+1); read is then served after DONE→IDLE.
- **Watchdog, `TIMEOUT`=16:** no resp after the address phase → at cycle 16 all enables are 0, `bmem_err` pulses once, and the bridge stays in ERR until requests drop. A resp exactly at cycle 16 → no error.
- **Reset mid-read after 3 words:** all outputs are 0 next cycle, no `bmem_rvalid`; a fresh read then completes normally.
- **Parameter sweep `BUS_W`=16, `CACHE_W`=64, `BEATS`=2:** 8 bus words per line; `bmem_rvalid` after words 4 and 8.
